// File: rtl/memory_align_unit.sv
// memory_align_unit: load/store alignment engine for a word-wide memory without
// byte enables. Loads are extracted and extended from a two-word window; stores
// are built as read-modify-write; word-crossing accesses are split in two.
module memory_align_unit #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [XLEN-1:0]   req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);
    localparam int WB    = XLEN / 8;
    localparam int OFF_W = $clog2(WB);
    // wide enough for off + nb and for any byte index of the two-word window
    localparam int CW    = OFF_W + 2;

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, MERGE, WR_LO, WR_HI, RESP} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   lo_reg, hi_reg;
    logic [OFF_W-1:0]    off_reg;
    logic [1:0]          size_reg;
    logic                signed_reg, write_reg, split_reg, err_reg;
    logic [XLEN-1:0]     wdata_reg, lo_word_reg, rdata_reg;
    logic [2*XLEN-1:0]   win_reg;

    // request decode, only ever feeds registers
    logic [ADDR_W-1:0]   req_lo;
    logic [OFF_W-1:0]    req_off;
    logic [CW-1:0]       req_nb, req_end;
    logic                req_split, req_bad, req_full;

    assign req_lo    = req_addr & ~ADDR_W'(WB - 1);
    assign req_off   = req_addr[OFF_W-1:0];
    assign req_nb    = CW'(1) << req_size;
    assign req_end   = CW'(req_off) + req_nb;
    assign req_split = req_end > CW'(WB);
    assign req_bad   = ((XLEN == 32) && (req_size == 2'd3)) || (req_split && !MISALIGN_EN);
    assign req_full  = req_write && (req_nb == CW'(WB)) && (req_off == '0);

    // merge datapath: window of {hi, lo} words, hi forced to zero when not split
    logic [CW-1:0]       nb_reg;
    logic [2*XLEN-1:0]   merge_win, store_shift, store_win;
    logic [XLEN-1:0]     load_shift, load_val;
    logic                sign_bit, sign_fill;

    assign nb_reg      = CW'(1) << size_reg;
    assign merge_win   = split_reg ? {mem_rdata, lo_word_reg} : {{XLEN{1'b0}}, mem_rdata};
    assign store_shift = {{XLEN{1'b0}}, wdata_reg} << {off_reg, 3'b000};
    assign load_shift  = XLEN'(merge_win >> {off_reg, 3'b000});

    // store: window bytes [off, off+nb) take the shifted store data
    generate
        for (genvar gi = 0; gi < 2 * WB; gi++) begin : g_win_byte
            logic [CW-1:0] rel;
            // wraps to a large value for bytes below off, so one compare covers both ends
            assign rel = CW'(gi) - CW'(off_reg);
            assign store_win[8*gi +: 8] = (rel < nb_reg) ? store_shift[8*gi +: 8]
                                                         : merge_win[8*gi +: 8];
        end
    endgenerate

    // pick the top bit of the loaded field for sign extension
    always_comb begin
        sign_bit = 1'b0;
        case (size_reg)
            2'd0:    sign_bit = load_shift[7];
            2'd1:    sign_bit = load_shift[15];
            2'd2:    sign_bit = load_shift[31];
            default: sign_bit = load_shift[XLEN-1];
        endcase
    end

    assign sign_fill = signed_reg & sign_bit;

    // load: keep the low nb bytes, fill the rest with sign or zero
    generate
        for (genvar gi = 0; gi < WB; gi++) begin : g_load_byte
            assign load_val[8*gi +: 8] = (CW'(gi) < nb_reg) ? load_shift[8*gi +: 8]
                                                            : {8{sign_fill}};
        end
    endgenerate

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // next state and state-decoded outputs
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)       state_next = RESP;
                    else if (req_full) state_next = WR_LO;
                    else               state_next = RD_LO;
                end
            end
            RD_LO: begin
                mem_rd_en  = 1'b1;
                mem_addr   = lo_reg;
                state_next = split_reg ? RD_HI : MERGE;
            end
            RD_HI: begin
                mem_rd_en  = 1'b1;
                mem_addr   = hi_reg;
                state_next = MERGE;
            end
            MERGE: begin
                state_next = write_reg ? WR_LO : RESP;
            end
            WR_LO: begin
                mem_wr_en  = 1'b1;
                mem_addr   = lo_reg;
                mem_wdata  = win_reg[XLEN-1:0];
                state_next = split_reg ? WR_HI : RESP;
            end
            WR_HI: begin
                mem_wr_en  = 1'b1;
                mem_addr   = hi_reg;
                mem_wdata  = win_reg[2*XLEN-1:XLEN];
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_reg;
                resp_err   = err_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // request latch, read capture and merge results
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_reg      <= '0;
            hi_reg      <= '0;
            off_reg     <= '0;
            size_reg    <= '0;
            signed_reg  <= 1'b0;
            write_reg   <= 1'b0;
            split_reg   <= 1'b0;
            err_reg     <= 1'b0;
            wdata_reg   <= '0;
            lo_word_reg <= '0;
            rdata_reg   <= '0;
            win_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        lo_reg     <= req_lo;
                        hi_reg     <= req_lo + ADDR_W'(WB);
                        off_reg    <= req_off;
                        size_reg   <= req_size;
                        signed_reg <= req_signed;
                        write_reg  <= req_write;
                        split_reg  <= req_split;
                        err_reg    <= req_bad;
                        wdata_reg  <= req_wdata;
                        rdata_reg  <= '0;
                        // an aligned full-word store writes the data unmodified
                        win_reg    <= {{XLEN{1'b0}}, req_wdata};
                    end
                end
                RD_HI: lo_word_reg <= mem_rdata;
                MERGE: begin
                    if (write_reg) win_reg   <= store_win;
                    else           rdata_reg <= load_val;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_align_unit.sv
// tb_memory_align_unit: table vectors, hand-written reset sequence and random
// traffic against a byte-array reference model.
module tb_memory_align_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  req_valid_v;
    logic [31:0] req_addr;
    logic        req_write, req_signed;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;

    logic        req_ready0, mem_rd_en0, mem_wr_en0, resp_valid0, resp_err0;
    logic [31:0] mem_addr0, mem_wdata0, resp_rdata0, rdata0 = '0;
    logic        req_ready1, mem_rd_en1, mem_wr_en1, resp_valid1, resp_err1;
    logic [31:0] mem_addr1, mem_wdata1, resp_rdata1, rdata1 = '0;
    logic        req_ready2, mem_rd_en2, mem_wr_en2, resp_valid2, resp_err2;
    logic [31:0] mem_addr2;
    logic [63:0] mem_wdata2, resp_rdata2, rdata2 = '0;

    memory_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid_v[0]), .req_ready(req_ready0),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata[31:0]), .mem_addr(mem_addr0), .mem_rd_en(mem_rd_en0),
        .mem_wr_en(mem_wr_en0), .mem_wdata(mem_wdata0), .mem_rdata(rdata0),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0));

    memory_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid_v[1]), .req_ready(req_ready1),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata[31:0]), .mem_addr(mem_addr1), .mem_rd_en(mem_rd_en1),
        .mem_wr_en(mem_wr_en1), .mem_wdata(mem_wdata1), .mem_rdata(rdata1),
        .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1));

    memory_align_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid_v[2]), .req_ready(req_ready2),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .mem_addr(mem_addr2), .mem_rd_en(mem_rd_en2),
        .mem_wr_en(mem_wr_en2), .mem_wdata(mem_wdata2), .mem_rdata(rdata2),
        .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .resp_err(resp_err2));

    // memories: byte array behind dut0, address-derived data for dut1, word array for dut2
    logic [7:0]  mem_a [0:1023];
    logic [63:0] mem_c [0:127];
    logic [7:0]  ref_mem [0:1023];
    logic [2:0]  bd_we = '0;
    logic [31:0] bd_addr = '0;
    logic [63:0] bd_data = '0;
    int rd_cnt [3] = '{0, 0, 0};
    int wr_cnt [3] = '{0, 0, 0};
    int both_hi = 0;
    int n_total = 0;
    int n_pass = 0;

    always @(posedge clk) begin
        if (bd_we[0]) for (int k = 0; k < 4; k++) mem_a[int'(bd_addr[9:0]) + k] <= bd_data[8*k +: 8];
        if (bd_we[2]) mem_c[bd_addr[9:3]] <= bd_data;
        if (mem_rd_en0) for (int k = 0; k < 4; k++) rdata0[8*k +: 8] <= mem_a[int'(mem_addr0[9:0]) + k];
        if (mem_wr_en0) for (int k = 0; k < 4; k++) mem_a[int'(mem_addr0[9:0]) + k] <= mem_wdata0[8*k +: 8];
        if (mem_rd_en1) rdata1 <= mem_addr1 ^ 32'hC0FFEE00;
        if (mem_rd_en2) rdata2 <= mem_c[mem_addr2[9:3]];
        if (mem_wr_en2) mem_c[mem_addr2[9:3]] <= mem_wdata2;
        rd_cnt[0] <= rd_cnt[0] + int'(mem_rd_en0);
        rd_cnt[1] <= rd_cnt[1] + int'(mem_rd_en1);
        rd_cnt[2] <= rd_cnt[2] + int'(mem_rd_en2);
        wr_cnt[0] <= wr_cnt[0] + int'(mem_wr_en0);
        wr_cnt[1] <= wr_cnt[1] + int'(mem_wr_en1);
        wr_cnt[2] <= wr_cnt[2] + int'(mem_wr_en2);
        if ((mem_rd_en0 && mem_wr_en0) || (mem_rd_en1 && mem_wr_en1) || (mem_rd_en2 && mem_wr_en2))
            both_hi <= both_hi + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic get_ready(int d);
        case (d) 0: return req_ready0; 1: return req_ready1; default: return req_ready2; endcase
    endfunction
    function automatic logic get_valid(int d);
        case (d) 0: return resp_valid0; 1: return resp_valid1; default: return resp_valid2; endcase
    endfunction
    function automatic logic get_err(int d);
        case (d) 0: return resp_err0; 1: return resp_err1; default: return resp_err2; endcase
    endfunction
    function automatic logic [63:0] get_rdata(int d);
        case (d) 0: return {32'b0, resp_rdata0}; 1: return {32'b0, resp_rdata1}; default: return resp_rdata2; endcase
    endfunction
    function automatic logic [63:0] rd_word(int d, logic [31:0] a);
        if (d == 2) return mem_c[a[9:3]];
        return {32'b0, mem_a[int'(a[9:0]) + 3], mem_a[int'(a[9:0]) + 2],
                mem_a[int'(a[9:0]) + 1], mem_a[int'(a[9:0])]};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    task automatic preset(input int d, input logic [31:0] a, input logic [63:0] v);
        @(negedge clk);
        bd_addr = a; bd_data = v; bd_we[d] = 1'b1;
        @(negedge clk);
        bd_we = '0;
    endtask

    // one request; scrambles the request inputs while busy to show they are ignored
    task automatic run(input int d, input logic [31:0] a, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [63:0] wd, output logic [63:0] rdata,
                       output logic err, output int lat, output int nrd, output int nwr);
        int rd0, wr0, busy_ready;
        bit got;
        @(negedge clk);
        chk("ready_idle", 64'(get_ready(d)), 64'd1);
        req_addr = a; req_write = wr; req_size = sz; req_signed = sg; req_wdata = wd;
        req_valid_v[d] = 1'b1;
        rd0 = rd_cnt[d]; wr0 = wr_cnt[d];
        got = 1'b0; lat = -1; rdata = '0; err = 1'b0; busy_ready = 0;
        @(posedge clk);
        for (int c = 1; c <= 12 && !got; c++) begin
            @(negedge clk);
            req_addr = $urandom; req_write = 1'($urandom); req_size = 2'($urandom);
            req_signed = 1'($urandom); req_wdata = {$urandom, $urandom};
            if (get_valid(d)) begin
                got = 1'b1; lat = c; rdata = get_rdata(d); err = get_err(d);
                req_valid_v[d] = 1'b0;
            end else if (get_ready(d)) begin
                busy_ready++;
            end
        end
        req_valid_v[d] = 1'b0;
        nrd = rd_cnt[d] - rd0; nwr = wr_cnt[d] - wr0;
        chk("ready_busy", 64'(busy_ready), 64'd0);
        @(negedge clk);
        chk("resp_pulse", 64'(get_valid(d)), 64'd0);
        chk("ready_after", 64'(get_ready(d)), 64'd1);
        $display("txn dut=%0d addr=%h %s size=%0d signed=%0d wdata=%h rdata=%h err=%0d lat=%0d rd=%0d wr=%0d",
                 d, a, wr ? "st" : "ld", sz, sg, wd, rdata, err, lat, nrd, nwr);
    endtask

    // reference: plain byte-array access by the architectural rules
    task automatic ref_access(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                              input logic sg, input logic [63:0] wd, output logic [63:0] er,
                              output logic ee, output int el, output int enr, output int enw);
        int nb, off;
        bit split;
        logic [63:0] v, mask;
        er = '0; ee = 1'b0; el = 1; enr = 0; enw = 0;
        if (sz == 2'd3) begin ee = 1'b1; return; end
        nb = 1 << sz; off = int'(a) % 4; split = (off + nb) > 4;
        if (!wr) begin
            v = '0;
            for (int k = 0; k < nb; k++) v |= 64'(ref_mem[int'(a) + k]) << (8 * k);
            mask = (64'd1 << (8 * nb)) - 64'd1;
            if (sg && v[8*nb-1]) v |= ~mask;
            er = v & 64'hFFFF_FFFF;
            el = split ? 4 : 3; enr = split ? 2 : 1;
        end else begin
            for (int k = 0; k < nb; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
            if (nb == 4 && off == 0) begin el = 2; enr = 0; end
            else begin el = split ? 6 : 4; enr = split ? 2 : 1; end
            enw = split ? 2 : 1;
        end
    endtask

    typedef struct {
        int d; logic [31:0] addr; logic wr; logic [1:0] sz; logic sg; logic [63:0] wd;
        logic [31:0] p_addr; logic [63:0] p0; logic [63:0] p1;
        logic [63:0] e_rdata; logic e_err; int e_lat; int e_nrd; int e_nwr;
        logic [63:0] e_m0; logic [63:0] e_m1;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    initial begin
        logic [63:0] rdata, er;
        logic err, ee;
        int lat, nrd, nwr, el, enr, enw, ws, mism, d0_wr;
        logic [31:0] a;
        logic [1:0] sz;
        logic wr, sg;
        logic [63:0] wd;
        logic [31:0] w;

        vt[0]  = '{0, 32'h103, 1'b0, 2'd0, 1'b1, 64'h0, 32'h100, 64'hA1B2C3D4, 64'h0,
                   64'hFFFFFFA1, 1'b0, 3, 1, 0, 64'hA1B2C3D4, 64'h0};
        vt[1]  = '{0, 32'h102, 1'b1, 2'd1, 1'b0, 64'hBEEF, 32'h100, 64'h11223344, 64'h0,
                   64'h0, 1'b0, 4, 1, 1, 64'hBEEF3344, 64'h0};
        vt[2]  = '{0, 32'h206, 1'b0, 2'd2, 1'b0, 64'h0, 32'h204, 64'h55667788, 64'h99AABBCC,
                   64'hBBCC5566, 1'b0, 4, 2, 0, 64'h55667788, 64'h99AABBCC};
        vt[3]  = '{0, 32'h207, 1'b1, 2'd2, 1'b0, 64'hDEADBEEF, 32'h204, 64'h55667788, 64'h99AABBCC,
                   64'h0, 1'b0, 6, 2, 2, 64'hEF667788, 64'h99DEADBE};
        vt[4]  = '{0, 32'h300, 1'b1, 2'd2, 1'b0, 64'h12345678, 32'h300, 64'hFFFFFFFF, 64'h0,
                   64'h0, 1'b0, 2, 0, 1, 64'h12345678, 64'h0};
        vt[5]  = '{0, 32'h302, 1'b0, 2'd1, 1'b1, 64'h0, 32'h300, 64'h80017FFF, 64'h0,
                   64'hFFFF8001, 1'b0, 3, 1, 0, 64'h80017FFF, 64'h0};
        vt[6]  = '{0, 32'h302, 1'b0, 2'd1, 1'b0, 64'h0, 32'h300, 64'h80017FFF, 64'h0,
                   64'h00008001, 1'b0, 3, 1, 0, 64'h80017FFF, 64'h0};
        vt[7]  = '{0, 32'h313, 1'b0, 2'd1, 1'b1, 64'h0, 32'h310, 64'hAABBCCDD, 64'h11223344,
                   64'h000044AA, 1'b0, 4, 2, 0, 64'hAABBCCDD, 64'h11223344};
        vt[8]  = '{0, 32'h320, 1'b0, 2'd3, 1'b1, 64'h0, 32'h320, 64'h12121212, 64'h34343434,
                   64'h0, 1'b1, 1, 0, 0, 64'h12121212, 64'h34343434};
        vt[9]  = '{0, 32'h331, 1'b1, 2'd0, 1'b0, 64'hFFFFFF5A, 32'h330, 64'h0, 64'h0,
                   64'h0, 1'b0, 4, 1, 1, 64'h00005A00, 64'h0};
        vt[10] = '{1, 32'h0FF, 1'b0, 2'd1, 1'b0, 64'h0, 32'h0, 64'h0, 64'h0,
                   64'h0, 1'b1, 1, 0, 0, 64'h0, 64'h0};
        vt[11] = '{1, 32'h0FE, 1'b0, 2'd1, 1'b0, 64'h0, 32'h0, 64'h0, 64'h0,
                   64'h0000C0FF, 1'b0, 3, 1, 0, 64'h0, 64'h0};
        vt[12] = '{1, 32'h0FD, 1'b1, 2'd2, 1'b0, 64'hCAFEF00D, 32'h0, 64'h0, 64'h0,
                   64'h0, 1'b1, 1, 0, 0, 64'h0, 64'h0};
        vt[13] = '{2, 32'h107, 1'b0, 2'd0, 1'b1, 64'h0, 32'h100, 64'hA1B2C3D4_55667788, 64'h01234567_89ABCDEF,
                   64'hFFFFFFFF_FFFFFFA1, 1'b0, 3, 1, 0, 64'hA1B2C3D4_55667788, 64'h01234567_89ABCDEF};
        vt[14] = '{2, 32'h104, 1'b0, 2'd3, 1'b0, 64'h0, 32'h100, 64'hA1B2C3D4_55667788, 64'h01234567_89ABCDEF,
                   64'h89ABCDEF_A1B2C3D4, 1'b0, 4, 2, 0, 64'hA1B2C3D4_55667788, 64'h01234567_89ABCDEF};
        vt[15] = '{2, 32'h104, 1'b0, 2'd2, 1'b1, 64'h0, 32'h100, 64'hA1B2C3D4_55667788, 64'h01234567_89ABCDEF,
                   64'hFFFFFFFF_A1B2C3D4, 1'b0, 3, 1, 0, 64'hA1B2C3D4_55667788, 64'h01234567_89ABCDEF};
        vt[16] = '{2, 32'h110, 1'b1, 2'd3, 1'b0, 64'h11223344_55667788, 32'h110, 64'hFFFFFFFF_FFFFFFFF, 64'h0,
                   64'h0, 1'b0, 2, 0, 1, 64'h11223344_55667788, 64'h0};
        vt[17] = '{2, 32'h10F, 1'b1, 2'd1, 1'b0, 64'hBEEF, 32'h108, 64'h01234567_89ABCDEF, 64'h11223344_55667788,
                   64'h0, 1'b0, 6, 2, 2, 64'hEF234567_89ABCDEF, 64'h11223344_556677BE};

        reset = 1'b1; req_valid_v = '0; req_addr = '0; req_write = 1'b0;
        req_size = '0; req_signed = 1'b0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready0), 64'd1);
        chk("rst_rd_en", 64'(mem_rd_en0), 64'd0);
        chk("rst_wr_en", 64'(mem_wr_en0), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid0), 64'd0);
        chk("rst_resp_err", 64'(resp_err0), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr0), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata0), 64'd0);
        chk("rst_resp_rdata", 64'(resp_rdata0), 64'd0);
        chk("rst_mem_addr64", 64'(mem_addr2), 64'd0);
        chk("rst_ready64", 64'(req_ready2), 64'd1);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            ws = (vt[i].d == 2) ? 8 : 4;
            if (vt[i].d != 1) begin
                preset(vt[i].d, vt[i].p_addr, vt[i].p0);
                preset(vt[i].d, vt[i].p_addr + 32'(ws), vt[i].p1);
            end
            run(vt[i].d, vt[i].addr, vt[i].wr, vt[i].sz, vt[i].sg, vt[i].wd, rdata, err, lat, nrd, nwr);
            chk($sformatf("vec%0d_rdata", i), rdata, vt[i].e_rdata);
            chk($sformatf("vec%0d_err", i), 64'(err), 64'(vt[i].e_err));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].e_lat));
            chk($sformatf("vec%0d_reads", i), 64'(nrd), 64'(vt[i].e_nrd));
            chk($sformatf("vec%0d_writes", i), 64'(nwr), 64'(vt[i].e_nwr));
            if (vt[i].d != 1) begin
                chk($sformatf("vec%0d_mem_lo", i), rd_word(vt[i].d, vt[i].p_addr), vt[i].e_m0);
                chk($sformatf("vec%0d_mem_hi", i), rd_word(vt[i].d, vt[i].p_addr + 32'(ws)), vt[i].e_m1);
            end
        end

        // reset while reading the high word of a split store: nothing gets written
        preset(0, 32'h204, 64'h55667788);
        preset(0, 32'h208, 64'h99AABBCC);
        @(negedge clk);
        req_addr = 32'h207; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_wdata = 64'hDEADBEEF; req_valid_v[0] = 1'b1;
        d0_wr = wr_cnt[0];
        @(negedge clk);
        req_valid_v[0] = 1'b0;
        @(negedge clk);
        chk("rsthi_rd_en", 64'(mem_rd_en0), 64'd1);
        chk("rsthi_addr", 64'(mem_addr0), 64'h208);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rsthi_ready", 64'(req_ready0), 64'd1);
        chk("rsthi_wr_en", 64'(mem_wr_en0), 64'd0);
        chk("rsthi_resp", 64'(resp_valid0), 64'd0);
        repeat (4) @(negedge clk);
        chk("rsthi_no_writes", 64'(wr_cnt[0] - d0_wr), 64'd0);
        chk("rsthi_mem_lo", rd_word(0, 32'h204), 64'h55667788);
        run(0, 32'h206, 1'b0, 2'd2, 1'b0, 64'h0, rdata, err, lat, nrd, nwr);
        chk("rsthi_recover", rdata, 64'hBBCC5566);

        // random traffic against the byte-array reference
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
            preset(0, 32'(4 * i), {32'b0, w});
        end
        for (int i = 0; i < 150; i++) begin
            a  = 32'($urandom_range(0, 1015));
            wr = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sg = 1'($urandom_range(0, 1));
            wd = {32'b0, $urandom};
            ref_access(a, wr, sz, sg, wd, er, ee, el, enr, enw);
            run(0, a, wr, sz, sg, wd, rdata, err, lat, nrd, nwr);
            chk($sformatf("rnd%0d_rdata", i), rdata, er);
            chk($sformatf("rnd%0d_err", i), 64'(err), 64'(ee));
            chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(el));
            chk($sformatf("rnd%0d_reads", i), 64'(nrd), 64'(enr));
            chk($sformatf("rnd%0d_writes", i), 64'(nwr), 64'(enw));
        end
        mism = 0;
        for (int i = 0; i < 1024; i++) if (mem_a[i] !== ref_mem[i]) mism++;
        chk("mem_final_mismatches", 64'(mism), 64'd0);
        chk("strobe_overlap", 64'(both_hi), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
